// File: rtl/group_accumulate_ctrl.sv
// Purpose : walks memory in NUM_GROUPS groups of GROUP words, writes one modulo-2**DATA_W sum per group.
// Latency : NUM_GROUPS*(2+W*(READ_LAT+1)) cycles from first CLEAR to final WRITE; ready pulses one cycle later.
// Backpr. : none; memory is assumed always ready, start is only honoured in IDLE and ignored while busy.
module group_accumulate_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int GROUP      = 8,
  parameter int NUM_GROUPS = 4,
  parameter int OUT_BASE   = 32,
  parameter int READ_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              ready,
  output logic              overflow,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data
);

  // g counts groups, k counts words inside a group, wcnt counts extra read-latency cycles
  localparam int GW  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int KW  = $clog2(GROUP);
  localparam int WCW = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state;
  logic              mode_q;
  logic [GW-1:0]     g;
  logic [KW-1:0]     k;
  logic [WCW-1:0]    wcnt;
  logic [DATA_W-1:0] acc;

  logic [ADDR_W-1:0] grp_base;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [KW-1:0]     k_inc;
  logic [KW-1:0]     k_last;
  logic              g_last;
  logic [DATA_W:0]   sum;

  // Address arithmetic, last-word index for the latched mode and the carry-extended sum
  always_comb begin
    grp_base     = ADDR_W'(g) * ADDR_W'(GROUP);
    k_inc        = k + KW'(1);
    rd_addr      = grp_base + ADDR_W'(k);
    rd_addr_next = grp_base + ADDR_W'(k_inc);
    // Mode 0 keeps the last word of the group as the destination, so it is never read
    k_last       = mode_q ? KW'(GROUP - 1) : KW'(GROUP - 2);
    wr_addr      = mode_q ? (ADDR_W'(OUT_BASE) + ADDR_W'(g))
                          : (grp_base + ADDR_W'(GROUP - 1));
    g_last       = (g == GW'(NUM_GROUPS - 1));
    sum          = {1'b0, acc} + {1'b0, mem_read_data};
  end

  // Sequencer: every output is registered and set on the transition into the state that owns it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      mode_q           <= 1'b0;
      g                <= '0;
      k                <= '0;
      wcnt             <= '0;
      acc              <= '0;
      busy             <= 1'b0;
      ready            <= 1'b0;
      overflow         <= 1'b0;
      mem_address      <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b0;
          if (start) begin
            mode_q   <= mode;
            overflow <= 1'b0;
            g        <= '0;
            k        <= '0;
            busy     <= 1'b1;
            state    <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          acc             <= '0;
          mem_address     <= rd_addr;
          mem_read_enable <= 1'b1;
          state           <= S_READ;
        end

        S_READ: begin
          mem_read_enable <= 1'b0;
          wcnt            <= '0;
          state           <= (READ_LAT > 1) ? S_WAIT : S_LOAD;
        end

        S_WAIT: begin
          if (wcnt == WCW'(READ_LAT - 2)) begin
            state <= S_LOAD;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end

        S_LOAD: begin
          acc <= sum[DATA_W-1:0];
          if (sum[DATA_W]) begin
            overflow <= 1'b1;
          end
          if (k < k_last) begin
            k               <= k_inc;
            mem_address     <= rd_addr_next;
            mem_read_enable <= 1'b1;
            state           <= S_READ;
          end else begin
            // Write data takes the fresh sum so the last word is included
            mem_address      <= wr_addr;
            mem_write_enable <= 1'b1;
            mem_write_data   <= sum[DATA_W-1:0];
            state            <= S_WRITE;
          end
        end

        S_WRITE: begin
          mem_write_enable <= 1'b0;
          if (!g_last) begin
            g     <= g + GW'(1);
            k     <= '0;
            state <= S_CLEAR;
          end else begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          ready <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_group_accumulate_ctrl.sv
// Bench for group_accumulate_ctrl: two instances (read latency 1 and 3) share one clock and reset.
// Each instance has its own memory model returning random junk outside the exact latency slot.
// Runs are checked against a whole-group arithmetic reference computed from a memory snapshot.
module tb_group_accumulate_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start_s [2];
  logic       mode_s  [2];
  logic       busy    [2];
  logic       ready   [2];
  logic       ovf     [2];
  logic       re      [2];
  logic       we      [2];
  logic [5:0] addr    [2];
  logic [7:0] rdata   [2];
  logic [7:0] wdata   [2];

  always #5 clock = ~clock;

  group_accumulate_ctrl #(.READ_LAT(1)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]), .mode(mode_s[0]),
    .busy(busy[0]), .ready(ready[0]), .overflow(ovf[0]),
    .mem_address(addr[0]), .mem_read_enable(re[0]), .mem_read_data(rdata[0]),
    .mem_write_enable(we[0]), .mem_write_data(wdata[0])
  );

  group_accumulate_ctrl #(.READ_LAT(3)) u_lat3 (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]), .mode(mode_s[1]),
    .busy(busy[1]), .ready(ready[1]), .overflow(ovf[1]),
    .mem_address(addr[1]), .mem_read_enable(re[1]), .mem_read_data(rdata[1]),
    .mem_write_enable(we[1]), .mem_write_data(wdata[1])
  );

  // ---------------- memory models ----------------
  logic [7:0] mem     [2][64];
  logic       wr_mask [2][64];
  logic       pv      [2][3];
  logic [7:0] pd      [2][3];
  logic [7:0] junk;
  int         preload_pat = 0;
  logic       preload_req = 1'b0;

  // Synchronous memory with a 3-deep read pipeline; preload fills and clears the write map
  always @(posedge clock) begin
    junk <= 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (preload_req) begin
        for (int a = 0; a < 64; a++) begin
          case (preload_pat)
            0:       mem[i][a] <= 8'(a);
            1:       mem[i][a] <= 8'hFF;
            2:       mem[i][a] <= 8'h00;
            default: mem[i][a] <= 8'($urandom);
          endcase
          wr_mask[i][a] <= 1'b0;
        end
      end else if (we[i]) begin
        mem[i][addr[i]]     <= wdata[i];
        wr_mask[i][addr[i]] <= 1'b1;
      end
      pv[i][0] <= re[i];
      pd[i][0] <= mem[i][addr[i]];
      for (int s = 1; s < 3; s++) begin
        pv[i][s] <= pv[i][s-1];
        pd[i][s] <= pd[i][s-1];
      end
    end
  end

  // Data is only genuine in the exact latency slot; any other cycle shows junk
  always_comb begin
    rdata[0] = pv[0][0] ? pd[0][0] : junk;
    rdata[1] = pv[1][2] ? pd[1][2] : junk;
  end

  // ---------------- monitors ----------------
  int   cyc = 0;
  int   ready_cnt [2] = '{0, 0};
  int   rd_cnt    [2] = '{0, 0};
  int   wr_cnt    [2] = '{0, 0};
  int   clash_cnt [2] = '{0, 0};
  int   rise_cyc  [2] = '{0, 0};
  int   rdy_cyc   [2] = '{0, 0};
  logic busy_d    [2] = '{1'b0, 1'b0};

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && !busy_d[i]) rise_cyc[i] <= cyc;
      busy_d[i] <= busy[i];
      if (ready[i]) begin
        ready_cnt[i] <= ready_cnt[i] + 1;
        rdy_cyc[i]   <= cyc;
      end
      if (re[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      if (we[i]) wr_cnt[i] <= wr_cnt[i] + 1;
      if (re[i] && we[i]) clash_cnt[i] <= clash_cnt[i] + 1;
    end
    cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic preload(input int pat);
    preload_pat = pat;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] snap    [64];
  logic [7:0] exp_mem [64];
  bit         exp_ov;

  // Whole-group sums with plain integers; overflow means some group's true sum exceeds a byte
  function automatic void compute(input bit md);
    int w;
    int s;
    int dst;
    exp_ov = 1'b0;
    for (int a = 0; a < 64; a++) exp_mem[a] = snap[a];
    w = md ? 8 : 7;
    for (int gi = 0; gi < 4; gi++) begin
      s = 0;
      for (int kk = 0; kk < w; kk++) s += int'(snap[gi*8 + kk]);
      dst = md ? (32 + gi) : (gi*8 + 7);
      exp_mem[dst] = 8'(s % 256);
      if (s > 255) exp_ov = 1'b1;
    end
  endfunction

  task automatic run(input int i, input bit md, input bit disturb);
    int  r0;
    int  c0;
    int  lat;
    int  w;
    bit  done;
    for (int a = 0; a < 64; a++) snap[a] = mem[i][a];
    compute(md);
    lat = (i == 0) ? 1 : 3;
    w   = md ? 8 : 7;
    r0  = ready_cnt[i];
    c0  = clash_cnt[i];
    start_s[i] = 1'b1;
    mode_s[i]  = md;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      if (busy[i]) begin
        if (disturb) begin
          start_s[i] = 1'($urandom_range(0, 1));
          mode_s[i]  = 1'($urandom_range(0, 1));
        end else begin
          start_s[i] = 1'b0;
        end
      end
      if (ready[i]) begin
        start_s[i] = 1'b0;
        done = 1'b1;
      end
    end
    chk($sformatf("run_done[%0d]", i), longint'(done), 1);
    chk($sformatf("run_cycles[%0d]", i), rdy_cyc[i] - rise_cyc[i], 4 * (2 + w * (lat + 1)));
    repeat (4) tick();
    chk($sformatf("ready_count[%0d]", i), ready_cnt[i] - r0, 1);
    chk($sformatf("busy_after[%0d]", i), longint'(busy[i]), 0);
    chk($sformatf("strobe_clash[%0d]", i), clash_cnt[i] - c0, 0);
    chk($sformatf("overflow[%0d]", i), longint'(ovf[i]), longint'(exp_ov));
    for (int a = 0; a < 64; a++)
      chk($sformatf("mem%0d[%0d]", i, a), longint'(mem[i][a]), longint'(exp_mem[a]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  r_rd;
    int  r_wr;
    bit  found;
    int  ri;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 1'b0;
    end
    repeat (3) tick();

    // Reset state of both instances
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy[%0d]", i), longint'(busy[i]), 0);
      chk($sformatf("rst_ready[%0d]", i), longint'(ready[i]), 0);
      chk($sformatf("rst_ovf[%0d]", i), longint'(ovf[i]), 0);
      chk($sformatf("rst_addr[%0d]", i), longint'(addr[i]), 0);
      chk($sformatf("rst_strobes[%0d]", i), longint'({re[i], we[i]}), 0);
      chk($sformatf("rst_wdata[%0d]", i), longint'(wdata[i]), 0);
    end
    reset_n = 1'b1;
    tick();

    // Mode 0, ascending data, latency 1
    preload(0);
    run(0, 1'b0, 1'b0);
    chk("t1_mem7", longint'(mem[0][7]), 21);
    chk("t1_mem15", longint'(mem[0][15]), 77);
    chk("t1_mem23", longint'(mem[0][23]), 133);
    chk("t1_mem31", longint'(mem[0][31]), 189);

    // Saturated data sets overflow, a clean run clears it
    preload(1);
    run(0, 1'b0, 1'b0);
    chk("t2_mem7", longint'(mem[0][7]), 8'hF9);
    chk("t2_ovf", longint'(ovf[0]), 1);
    preload(2);
    run(0, 1'b0, 1'b0);
    chk("t2_ovf_clr", longint'(ovf[0]), 0);

    // Mode 1 writes to the separate output region
    preload(0);
    run(0, 1'b1, 1'b0);
    chk("t3_mem32", longint'(mem[0][32]), 28);
    chk("t3_mem35", longint'(mem[0][35]), 220);
    chk("t3_mem31", longint'(mem[0][31]), 31);

    // Latency 3 instance on the same data
    preload(0);
    run(1, 1'b0, 1'b0);
    chk("t4_mem31", longint'(mem[1][31]), 189);

    // Reset in the middle of group 2
    preload(0);
    start_s[0] = 1'b1;
    mode_s[0]  = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      tick();
      if (busy[0]) start_s[0] = 1'b0;
      if (re[0] && addr[0] == 6'd16) found = 1'b1;
    end
    chk("t5_reached_g2", longint'(found), 1);
    reset_n = 1'b0;
    #1;
    chk("t5_outs_zero", longint'({busy[0], ready[0], ovf[0], re[0], we[0], addr[0], wdata[0]}), 0);
    r_rd = rd_cnt[0];
    r_wr = wr_cnt[0];
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("t5_no_reads", rd_cnt[0] - r_rd, 0);
    chk("t5_no_writes", wr_cnt[0] - r_wr, 0);
    for (int a = 0; a < 64; a++)
      chk($sformatf("t5_wmask[%0d]", a), longint'(wr_mask[0][a]), longint'(a == 7 || a == 15));
    run(0, 1'b0, 1'b0);
    chk("t5_rerun_mem23", longint'(mem[0][23]), 133);

    // start and mode toggled while busy
    preload(0);
    run(0, 1'b0, 1'b1);
    preload(0);
    run(1, 1'b1, 1'b1);

    // Random contents, modes and instances
    for (int t = 0; t < 8; t++) begin
      preload(3);
      ri = $urandom_range(0, 1);
      run(ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound in case a run never returns
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
